// File: rtl/mem_cmd_parser.sv
// mem_cmd_parser: byte-serial command front-end for a DFF memory array.
//
// Each command byte carries an opcode in [7:6] (00 NOP, 01 WRITE, 10 READ,
// 11 FILL) and an address in [ADDR_W-1:0]. The parser turns these commands
// into single-cycle memory strobes and returns read data on a valid/ready
// response channel. FILL writes one data byte to every address in the array.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_data     command/data byte stream (valid/ready)
//   in_ready             byte accepted this cycle when in_valid is also high
//   mem_we/mem_re        one-cycle write/read strobes, never both high
//   mem_addr/mem_wdata   memory address and write data, held between strobes
//   mem_rdata            memory read data, valid one cycle after mem_re
//   out_valid/out_data   read response (valid/ready), out_ready from downstream
//   busy                 high whenever the parser is not idle
module mem_cmd_parser #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StGetData,
        StWr,
        StReadReq,
        StReadWait,
        StResp,
        StFillRun
    } state_e;

    state_e              state_q, state_d;
    logic                fill_q, fill_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Command bits between the opcode and the address field are don't-care.
    logic unused_in_bits;
    assign unused_in_bits = ^in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            fill_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    case (in_data[7:6])
                        2'b01: begin
                            addr_d  = in_data[ADDR_W-1:0];
                            fill_d  = 1'b0;
                            state_d = StGetData;
                        end
                        2'b10: begin
                            addr_d  = in_data[ADDR_W-1:0];
                            state_d = StReadReq;
                        end
                        2'b11: begin
                            // FILL ignores the address field.
                            fill_d  = 1'b1;
                            state_d = StGetData;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StGetData: begin
                if (in_valid) begin
                    wdata_d = DATA_W'(in_data);
                    if (fill_q) begin
                        addr_d  = '0;
                        state_d = StFillRun;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            StWr:       state_d = StIdle;
            StReadReq:  state_d = StReadWait;
            StReadWait: begin
                rdata_d = mem_rdata;
                state_d = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            StFillRun: begin
                // Stop on the last address; mem_addr stays there, no wrap.
                if (addr_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) || (state_q == StGetData);
        mem_we    = (state_q == StWr) || (state_q == StFillRun);
        mem_re    = (state_q == StReadReq);
        out_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        out_data  = rdata_q;
    end

endmodule

// File: tb/tb_mem_cmd_parser.sv
// Directed, table-driven bench for mem_cmd_parser with a small memory model.
module tb_mem_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_cmd_parser #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    // Memory model: address 3 preloaded with 0x3C, read data one cycle after mem_re.
    logic [7:0] mem [16] = '{3: 8'h3C, default: 8'h00};
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Packed view: {in_ready, mem_we, mem_re, mem_addr, mem_wdata, out_valid, out_data, busy}
    function automatic logic [24:0] pk(input logic ir, input logic we, input logic re,
                                       input logic [3:0] a, input logic [7:0] wd,
                                       input logic ov, input logic [7:0] od, input logic b);
        return {ir, we, re, a, wd, ov, od, b};
    endfunction

    logic [24:0] act;
    assign act = {in_ready, mem_we, mem_re, mem_addr, mem_wdata, out_valid, out_data, busy};

    typedef struct {
        logic        chk;
        logic        rst;
        logic        iv;
        logic [7:0]  id;
        logic        ordy;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic chk, input logic r, input logic iv, input logic [7:0] id,
                       input logic ordy, input logic [24:0] exp);
        vec_t v;
        v.chk = chk; v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One cycle: drive inputs after the falling edge, check outputs of that cycle.
    task automatic cyc(input string name, input logic chk, input logic r, input logic iv,
                       input logic [7:0] id, input logic ordy, input logic [24:0] exp);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        if (chk) begin
            checks++;
            if (mem_we && mem_re) begin
                errors++;
                $display("FAIL %s: mem_we and mem_re both high", name);
            end else if (act !== exp) begin
                errors++;
                $display("FAIL %s: got ir/we/re/addr/wd/ov/od/busy=%b/%b/%b/%h/%h/%b/%h/%b want %b/%b/%b/%h/%h/%b/%h/%b",
                         name, act[24], act[23], act[22], act[21:18], act[17:10], act[9],
                         act[8:1], act[0], exp[24], exp[23], exp[22], exp[21:18], exp[17:10],
                         exp[9], exp[8:1], exp[0]);
            end
        end
    endtask

    logic [24:0] idle0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        idle0 = pk(1, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0);

        // Reset mid-stream, WRITE 5<-A5, READ 3 with backpressure, NOP, stalled WRITE.
        add(0, 1, 1, 8'h45, 0, idle0);
        add(1, 1, 1, 8'h45, 0, idle0);
        add(1, 0, 1, 8'h45, 0, idle0);
        add(1, 0, 1, 8'hA5, 0, pk(1, 0, 0, 4'h5, 8'h00, 0, 8'h00, 1));
        add(1, 0, 0, 8'h00, 0, pk(0, 1, 0, 4'h5, 8'hA5, 0, 8'h00, 1));
        add(1, 0, 1, 8'h83, 0, pk(1, 0, 0, 4'h5, 8'hA5, 0, 8'h00, 0));
        add(1, 0, 0, 8'h00, 0, pk(0, 0, 1, 4'h3, 8'hA5, 0, 8'h00, 1));
        add(1, 0, 1, 8'hC0, 0, pk(0, 0, 0, 4'h3, 8'hA5, 0, 8'h00, 1));
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 8'h00, 0, pk(0, 0, 0, 4'h3, 8'hA5, 1, 8'h3C, 1));
        add(1, 0, 0, 8'h00, 1, pk(0, 0, 0, 4'h3, 8'hA5, 1, 8'h3C, 1));
        add(1, 0, 1, 8'h00, 0, pk(1, 0, 0, 4'h3, 8'hA5, 0, 8'h3C, 0));
        add(1, 0, 1, 8'h4F, 0, pk(1, 0, 0, 4'h3, 8'hA5, 0, 8'h3C, 0));
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 8'h11, 0, pk(1, 0, 0, 4'hF, 8'hA5, 0, 8'h3C, 1));
        add(1, 0, 1, 8'h11, 0, pk(1, 0, 0, 4'hF, 8'hA5, 0, 8'h3C, 1));
        add(1, 0, 0, 8'h00, 0, pk(0, 1, 0, 4'hF, 8'h11, 0, 8'h3C, 1));
        add(1, 0, 0, 8'h00, 0, pk(1, 0, 0, 4'hF, 8'h11, 0, 8'h3C, 0));

        foreach (vecs[i])
            cyc($sformatf("vec%0d", i), vecs[i].chk, vecs[i].rst, vecs[i].iv, vecs[i].id,
                vecs[i].ordy, vecs[i].exp);

        // FILL with 0x77: 16 writes at addresses 0..15, then idle.
        cyc("fill_cmd", 1, 0, 1, 8'hC0, 0, pk(1, 0, 0, 4'hF, 8'h11, 0, 8'h3C, 0));
        cyc("fill_data", 1, 0, 1, 8'h77, 0, pk(1, 0, 0, 4'hF, 8'h11, 0, 8'h3C, 1));
        for (int i = 0; i < 16; i++)
            cyc($sformatf("fill_wr%0d", i), 1, 0, 1, 8'h45, 0,
                pk(0, 1, 0, 4'(i), 8'h77, 0, 8'h3C, 1));
        cyc("fill_done", 1, 0, 0, 8'h00, 0, pk(1, 0, 0, 4'hF, 8'h77, 0, 8'h3C, 0));

        // FILL with 0x5A aborted by reset after six writes.
        cyc("fill2_cmd", 1, 0, 1, 8'hC5, 0, pk(1, 0, 0, 4'hF, 8'h77, 0, 8'h3C, 0));
        cyc("fill2_data", 1, 0, 1, 8'h5A, 0, pk(1, 0, 0, 4'hF, 8'h77, 0, 8'h3C, 1));
        for (int i = 0; i < 6; i++)
            cyc($sformatf("fill2_wr%0d", i), 1, (i == 5), 0, 8'h00, 0,
                pk(0, 1, 0, 4'(i), 8'h5A, 0, 8'h3C, 1));
        cyc("abort_rst", 1, 1, 0, 8'h00, 0, idle0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("abort_idle%0d", i), 1, 0, 0, 8'h00, 0, idle0);

        // READ 2 after the aborted fill returns 0x5A; out_ready already high.
        cyc("rd2_cmd", 1, 0, 1, 8'h82, 1, idle0);
        cyc("rd2_req", 1, 0, 0, 8'h00, 1, pk(0, 0, 1, 4'h2, 8'h00, 0, 8'h00, 1));
        cyc("rd2_wait", 1, 0, 0, 8'h00, 1, pk(0, 0, 0, 4'h2, 8'h00, 0, 8'h00, 1));
        cyc("rd2_resp", 1, 0, 0, 8'h00, 1, pk(0, 0, 0, 4'h2, 8'h00, 1, 8'h5A, 1));
        cyc("rd2_done", 1, 0, 0, 8'h00, 0, pk(1, 0, 0, 4'h2, 8'h00, 0, 8'h5A, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
